// File: rtl/comp_seq.sv
// Multi-cycle magnitude comparator: walks a WIDTH-bit operand pair through a 2-bit cascade slice, MSB pair first.
// Latency: 2 cycles (top pair differs) up to WIDTH/2+1 cycles (equal operands); one compare per latency+1 cycles.
// Backpressure: none; start is honoured only in IDLE and ignored while busy (RUN/DONE).
//
// Ports:
//   clk, reset_n     rising-edge clock, synchronous active-low reset
//   start            compare request, sampled in IDLE only
//   a, b             operands, latched on accepted start
//   signed_mode      1 = two's-complement compare, latched on accepted start
//   busy             high in RUN and DONE
//   done             one-cycle pulse, eq/gt/lt valid
//   eq, gt, lt       result flags, held until the next accepted start clears them
module comp_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NP = WIDTH / 2;
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cur_q;
  logic             cas_eq_q, cas_gt_q;
  logic             busy_q, done_q, eq_q, gt_q, lt_q;

  logic [WIDTH-1:0] msb_mask;
  logic [1:0]       a2, b2;
  logic             cas_eq_d, cas_gt_d;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the cascade itself never needs to know about signs.
  assign msb_mask = {signed_mode, {(WIDTH-1){1'b0}}};

  // Pair selected by the cursor.
  always_comb begin
    a2 = 2'b00;
    b2 = 2'b00;
    for (int i = 0; i < NP; i++) begin
      if (cur_q == CW'(i)) begin
        a2 = a_q[2*i +: 2];
        b2 = b_q[2*i +: 2];
      end
    end
  end

  // Cascade step: once a difference is found the verdict is frozen.
  always_comb begin
    cas_eq_d = cas_eq_q;
    cas_gt_d = cas_gt_q;
    if (cas_eq_q) begin
      cas_eq_d = (a2 == b2);
      cas_gt_d = (a2 > b2);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cur_q    <= '0;
      cas_eq_q <= 1'b1;
      cas_gt_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a ^ msb_mask;
            b_q      <= b ^ msb_mask;
            cur_q    <= CW'(NP - 1);
            cas_eq_q <= 1'b1;
            cas_gt_q <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          cas_eq_q <= cas_eq_d;
          cas_gt_q <= cas_gt_d;
          if (!cas_eq_d || (cur_q == '0)) begin
            // Result flags are loaded with the post-step cascade so they are
            // valid in the same cycle as the done pulse.
            state_q <= S_DONE;
            done_q  <= 1'b1;
            eq_q    <= cas_eq_d;
            gt_q    <= cas_gt_d;
            lt_q    <= ~cas_eq_d & ~cas_gt_d;
          end else begin
            cur_q <= cur_q - CW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_comp_seq.sv
// Testbench for comp_seq: directed vector table, multi-cycle corner sequences, randomized compares vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_comp_seq;

  localparam int W  = 16;
  localparam int NP = W / 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         signed_mode;
  logic         busy, done, eq, gt, lt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  comp_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt)
  );

  // res is {eq, gt, lt}; cyc is the cycle number of the done pulse.
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           s;
    int           cyc;
    logic [2:0]   res;
  } vec_t;

  vec_t vecs[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Done cycle: first differing pair from the MSB end decides the step count.
  function automatic int ref_cycles(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = 0; i < NP; i++)
      if (x[W-1-2*i -: 2] != y[W-1-2*i -: 2]) return i + 2;
    return NP + 1;
  endfunction

  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
    logic lt_v;
    if (x == y) return 3'b100;
    lt_v = s ? ($signed(x) < $signed(y)) : (x < y);
    return lt_v ? 3'b001 : 3'b010;
  endfunction

  // mode 0: start dropped after acceptance, operands scrambled to fixed junk.
  // mode 1: random operands / signed_mode / start pulses while busy.
  // mode 2: start held high throughout, operands unchanged (back-to-back).
  task automatic run_cmp(input logic [W-1:0] xa, input logic [W-1:0] xb, input bit s,
                         input int mode, input int exp_cyc, input logic [2:0] exp_res);
    int c;
    a = xa; b = xb; signed_mode = s; start = 1'b1;
    tick;
    c = 1;
    chk("busy_c1", 32'(busy), 32'd1);
    chk("clear_c1", 32'({eq, gt, lt}), 32'd0);
    start = (mode != 0);
    while (!done) begin
      chk("busy_run", 32'(busy), 32'd1);
      if (mode == 0) begin
        a = '1; b = '0; signed_mode = ~s;
      end else if (mode == 1) begin
        a = W'($urandom); b = W'($urandom);
        signed_mode = 1'($urandom); start = 1'($urandom);
      end
      tick;
      c++;
      if (c > NP + 4) begin
        chk("done_timeout", 32'(c), 32'(exp_cyc));
        start = 1'b0;
        return;
      end
    end
    chk("done_cycle", 32'(c), 32'(exp_cyc));
    chk("result", 32'({eq, gt, lt}), 32'(exp_res));
    chk("busy_done", 32'(busy), 32'd1);
    // start in the done cycle must be ignored.
    start = (mode != 0);
    tick;
    chk("idle_after", 32'({busy, done}), 32'd0);
    chk("hold", 32'({eq, gt, lt}), 32'(exp_res));
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y;
    bit           s, seen;

    reset_n = 1'b0; start = 1'b1; a = 16'h1111; b = 16'h0000; signed_mode = 1'b0;
    tick;
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'({eq, gt, lt}), 32'd0);
    start = 1'b0; reset_n = 1'b1;
    tick;
    chk("rst_no_start", 32'({busy, done}), 32'd0);

    vecs.push_back('{16'h1234, 16'h1234, 1'b0, 9, 3'b100});
    vecs.push_back('{16'h8000, 16'h0000, 1'b0, 2, 3'b010});
    vecs.push_back('{16'h8000, 16'h0000, 1'b1, 2, 3'b001});
    vecs.push_back('{16'h00FE, 16'h00FF, 1'b0, 9, 3'b001});
    vecs.push_back('{16'h0003, 16'h0005, 1'b0, 8, 3'b001});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, 2, 3'b001});
    vecs.push_back('{16'h7FFF, 16'h8000, 1'b1, 2, 3'b010});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 9, 3'b100});
    foreach (vecs[i]) run_cmp(vecs[i].a, vecs[i].b, vecs[i].s, 0, vecs[i].cyc, vecs[i].res);

    // Back-to-back with start held high.
    repeat (3) run_cmp(16'h0003, 16'h0005, 1'b0, 2, 8, 3'b001);

    // Start pulses and operand churn during RUN.
    run_cmp(16'h00FE, 16'h00FF, 1'b0, 1, 9, 3'b001);

    // Reset mid-RUN abandons the compare.
    a = 16'h5555; b = 16'h5555; signed_mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_res", 32'({eq, gt, lt}), 32'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      tick;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 32'd0);

    // Randomized compares, biased towards shared prefixes.
    repeat (150) begin
      x = W'($urandom);
      case ($urandom_range(0, 2))
        0:       y = x;
        1:       y = x ^ (W'(1) << $urandom_range(0, W - 1));
        default: y = W'($urandom);
      endcase
      s = 1'($urandom);
      run_cmp(x, y, s, int'($urandom_range(0, 2)), ref_cycles(x, y), ref_res(x, y, s));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
